// File: rtl/qam_param_mapper.sv
// Runtime-configurable constellation mapper: unpacks input words into cfg_bps-bit
// symbols, maps each through a writable LUT and streams the samples out.
module qam_param_mapper #(
    parameter int IN_WIDTH  = 32,
    parameter int MAX_BPS   = 8,
    parameter int SYM_WIDTH = 32,
    parameter     MEMINIT   = "qam_default.mif"
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic [3:0]           cfg_bps,
    input  logic                 cfg_we,
    input  logic [MAX_BPS-1:0]   cfg_addr,
    input  logic [SYM_WIDTH-1:0] cfg_wdata,
    output logic                 cfg_err,
    input  logic [IN_WIDTH-1:0]  t0_data,
    input  logic                 t0_last,
    input  logic                 t0_valid,
    output logic                 t0_ready,
    output logic [SYM_WIDTH-1:0] i_data,
    output logic                 i_last,
    output logic                 i_valid,
    input  logic                 i_ready
);
    localparam int AW = IN_WIDTH + MAX_BPS;
    localparam int CW = $clog2(AW + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MAP  = 1'b1;

    logic [0:0]         state, nxt_state;
    logic [AW-1:0]      acc, nxt_acc;
    logic [CW-1:0]      cnt, nxt_cnt;
    logic [3:0]         bps, nxt_bps;
    logic               q_last, nxt_last;
    logic               run;
    logic               err_set;

    logic               emit, emit_last;
    logic [MAX_BPS-1:0] emit_idx;

    logic [SYM_WIDTH-1:0] lut [0:(1<<MAX_BPS)-1];
    logic [SYM_WIDTH-1:0] rd_q;
    logic                 rd_vld, rd_last;

    logic [SYM_WIDTH-1:0] fdat [2];
    logic [1:0]           flast;
    logic                 wptr, rptr;
    logic [1:0]           fcnt;

    logic [CW-1:0] bps_w;
    logic          have_sym, pop, slot;
    logic [2:0]    inflight;
    logic [3:0]    bps_in;
    logic          bps_bad;

    function automatic logic [MAX_BPS-1:0] lo_mask(input logic [CW-1:0] n);
        logic [AW-1:0] m;
        m = (AW'(1) << n) - AW'(1);
        return m[MAX_BPS-1:0];
    endfunction

    assign bps_w    = CW'(bps);
    assign have_sym = (cnt >= bps_w);
    assign pop      = i_valid & i_ready;
    // Emit only if the registered read can still land in the buffer next cycle
    assign inflight = {1'b0, fcnt} + {2'b0, rd_vld} - {2'b0, pop};
    assign slot     = (inflight <= 3'd1);

    assign bps_bad = (cfg_bps == 4'd0) || (cfg_bps > 4'(MAX_BPS));
    assign bps_in  = (cfg_bps == 4'd0) ? 4'd1 :
                     (cfg_bps > 4'(MAX_BPS)) ? 4'(MAX_BPS) : cfg_bps;

    always_comb begin
        t0_ready  = 1'b0;
        emit      = 1'b0;
        emit_idx  = '0;
        emit_last = 1'b0;
        err_set   = 1'b0;
        nxt_state = state;
        nxt_acc   = acc;
        nxt_cnt   = cnt;
        nxt_bps   = bps;
        nxt_last  = q_last;
        case (state)
            S_IDLE: begin
                t0_ready = run;
                if (run && t0_valid) begin
                    nxt_bps   = bps_in;
                    err_set   = bps_bad;
                    nxt_acc   = AW'(t0_data);
                    nxt_cnt   = CW'(IN_WIDTH);
                    nxt_last  = t0_last;
                    nxt_state = S_MAP;
                end
            end
            default: begin
                if (have_sym) begin
                    if (slot) begin
                        emit      = 1'b1;
                        emit_idx  = acc[MAX_BPS-1:0] & lo_mask(bps_w);
                        emit_last = q_last && (cnt == bps_w);
                        nxt_acc   = acc >> bps;
                        nxt_cnt   = cnt - bps_w;
                    end
                end else if (!q_last) begin
                    t0_ready = 1'b1;
                    if (t0_valid) begin
                        nxt_acc  = acc | (AW'(t0_data) << cnt);
                        nxt_cnt  = cnt + CW'(IN_WIDTH);
                        nxt_last = t0_last;
                    end
                end else if (cnt == '0) begin
                    nxt_state = S_IDLE;
                    nxt_last  = 1'b0;
                end else if (slot) begin
                    // Residual bits of the frame: pad with zeros above cnt
                    emit      = 1'b1;
                    emit_idx  = acc[MAX_BPS-1:0] & lo_mask(cnt);
                    emit_last = 1'b1;
                    nxt_acc   = '0;
                    nxt_cnt   = '0;
                    nxt_last  = 1'b0;
                    nxt_state = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            bps     <= '0;
            q_last  <= 1'b0;
            run     <= 1'b0;
            cfg_err <= 1'b0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            state   <= nxt_state;
            acc     <= nxt_acc;
            cnt     <= nxt_cnt;
            bps     <= nxt_bps;
            q_last  <= nxt_last;
            run     <= 1'b1;
            cfg_err <= cfg_err | err_set;
            rd_vld  <= emit;
            rd_last <= emit_last;
        end
    end

    // LUT has no reset; a same-address write and read in one cycle returns old data
    always_ff @(posedge clk) begin
        if (cfg_we) lut[cfg_addr] <= cfg_wdata;
        if (emit)   rd_q <= lut[emit_idx];
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            fdat[0] <= '0;
            fdat[1] <= '0;
            flast   <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            fcnt    <= '0;
        end else begin
            if (rd_vld) begin
                fdat[wptr]  <= rd_q;
                flast[wptr] <= rd_last;
                wptr        <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            fcnt <= fcnt + {1'b0, rd_vld} - {1'b0, pop};
        end
    end

    assign i_valid = (fcnt != 2'd0);
    assign i_data  = fdat[rptr];
    assign i_last  = i_valid & flast[rptr];

endmodule

// File: tb/tb_qam_param_mapper.sv
// Self-checking bench for qam_param_mapper: directed vector table, corner sequences
// and randomized frames scored against a bit-queue reference model.
module tb_qam_param_mapper;
    localparam int IW = 32;
    localparam int MB = 8;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rstf = 1'b0;
    logic [3:0]    cfg_bps = 4'd4;
    logic          cfg_we = 1'b0;
    logic [MB-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_wdata = '0;
    logic          cfg_err;
    logic [IW-1:0] t0_data = '0;
    logic          t0_last = 1'b0;
    logic          t0_valid = 1'b0;
    logic          t0_ready;
    logic [SW-1:0] i_data;
    logic          i_last;
    logic          i_valid;
    logic          i_ready;

    qam_param_mapper #(.IN_WIDTH(IW), .MAX_BPS(MB), .SYM_WIDTH(SW)) dut (
        .clk(clk), .rstf(rstf), .cfg_bps(cfg_bps), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .t0_data(t0_data), .t0_last(t0_last), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i_data(i_data), .i_last(i_last), .i_valid(i_valid), .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [SW-1:0] d; logic l; } smp_t;
    typedef struct {
        int bps; int nw; logic [31:0] w0; logic [31:0] w1;
        int rm; int exp_n; logic [31:0] exp_last;
    } vec_t;

    smp_t          exp_q[$];
    logic [SW-1:0] lut_m [256];
    int            checks = 0;
    int            fails = 0;
    int            rx_cnt = 0;
    logic [SW-1:0] rx_last = '0;
    int            rmode = 0;
    logic          hold_chk = 1'b0;
    logic [SW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    vec_t          vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: flatten the frame into a bit list, cut into bps-sized chunks
    task automatic model_frame(input int bps_cfg, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input int nw);
        bit          bits[$];
        logic [31:0] word;
        logic [7:0]  idx;
        int          b, n, pos;
        smp_t        s;
        b = (bps_cfg == 0) ? 1 : (bps_cfg > MB) ? MB : bps_cfg;
        for (int k = 0; k < nw; k++) begin
            word = (k == 0) ? w0 : (k == 1) ? w1 : w2;
            for (int i = 0; i < 32; i++) bits.push_back(word[i]);
        end
        n = bits.size();
        pos = 0;
        while (pos < n) begin
            idx = '0;
            for (int j = 0; j < b; j++) if (pos + j < n) idx[j] = bits[pos + j];
            pos += b;
            s.d = lut_m[idx];
            s.l = (pos >= n);
            exp_q.push_back(s);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        t0_valid = 1'b1; t0_data = d; t0_last = l;
        @(negedge clk);
        while (!t0_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!t0_ready) chk("t0_accept_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        t0_valid = 1'b0;
    endtask

    task automatic send_frame(input int bps_cfg, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input int nw);
        model_frame(bps_cfg, w0, w1, w2, nw);
        cfg_bps = 4'(bps_cfg);
        for (int k = 0; k < nw; k++) begin
            send_word((k == 0) ? w0 : (k == 1) ? w1 : w2, k == nw - 1);
            if (k == 0) cfg_bps = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [7:0] a, input logic [SW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        lut_m[a] = d;
    endtask

    initial begin
        int ph;
        ph = 0;
        i_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: i_ready = 1'b1;
                1: i_ready = 1'($urandom_range(0, 1));
                2: begin i_ready = (ph == 0); ph = (ph + 1) % 4; end
                default: i_ready = 1'b0;
            endcase
        end
    end

    initial begin
        smp_t e;
        forever begin
            @(negedge clk);
            if (!rstf) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    checks++;
                    if (!i_valid || i_data !== hold_d || i_last !== hold_l) begin
                        fails++;
                        $display("FAIL hold_stable actual=%0b/%0h/%0b required=1/%0h/%0b",
                                 i_valid, i_data, i_last, hold_d, hold_l);
                    end
                end
                hold_chk = i_valid && !i_ready;
                hold_d = i_data;
                hold_l = i_last;
                if (i_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_sample actual=%0h/%0b required=none", i_data, i_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sample_data", 64'(i_data), 64'(e.d));
                        chk("sample_last", 64'(i_last), 64'(e.l));
                    end
                    rx_cnt++;
                    rx_last = i_data;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n;
        vt[0] = '{4, 1, 32'h76543210, 32'h0,        0, 8,  32'h7};
        vt[1] = '{5, 1, 32'hFFFFFFFF, 32'h0,        0, 7,  32'h3};
        vt[2] = '{6, 2, 32'h12345678, 32'h9ABCDEF0, 0, 11, 32'h9};
        vt[3] = '{2, 1, 32'hE4E4E4E4, 32'h0,        2, 16, 32'h3};
        vt[4] = '{8, 1, 32'hA5C30F81, 32'h0,        1, 4,  32'hA5};
        vt[5] = '{3, 1, 32'hFFFFFFFF, 32'h0,        0, 11, 32'h3};
        vt[6] = '{7, 2, 32'h00000000, 32'hFFFFFFFF, 1, 10, 32'h1};

        @(negedge clk);
        chk("rst_i_valid", 64'(i_valid), 64'd0);
        chk("rst_i_last", 64'(i_last), 64'd0);
        chk("rst_i_data", 64'(i_data), 64'd0);
        chk("rst_t0_ready", 64'(t0_ready), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        @(posedge clk); #1;
        rstf = 1'b1;

        for (int k = 0; k < 256; k++) lut_write(8'(k), SW'(k));

        for (int v = 0; v < 7; v++) begin
            rmode = vt[v].rm;
            start = rx_cnt;
            send_frame(vt[v].bps, vt[v].w0, vt[v].w1, 32'h0, vt[v].nw);
            drain();
            chk($sformatf("vec%0d_count", v), 64'(rx_cnt - start), 64'(vt[v].exp_n));
            chk($sformatf("vec%0d_final", v), 64'(rx_last), 64'(vt[v].exp_last));
        end
        chk("cfg_err_clean", 64'(cfg_err), 64'd0);

        // Mid-frame LUT write while the output is stalled: only the two looked-up samples keep old data
        rmode = 3;
        repeat (3) @(posedge clk);
        #1;
        start = rx_cnt;
        send_frame(2, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("stall_no_transfer", 64'(rx_cnt - start), 64'd0);
        lut_write(8'd3, 32'hCAFE0003);
        for (int i = 2; i < exp_q.size(); i++) exp_q[i].d = 32'hCAFE0003;
        rmode = 0;
        drain();
        chk("lutwr_count", 64'(rx_cnt - start), 64'd16);
        chk("lutwr_final", 64'(rx_last), 64'hCAFE0003);
        lut_write(8'd3, 32'd3);

        for (int k = 0; k < 256; k++) lut_write(8'(k), $urandom);
        rmode = 1;
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, MB), $urandom, $urandom, $urandom, $urandom_range(1, 3));
            drain();
        end
        chk("cfg_err_after_random", 64'(cfg_err), 64'd0);

        for (int k = 0; k < 256; k++) lut_write(8'(k), SW'(k));
        rmode = 0;
        start = rx_cnt;
        send_frame(0, 32'h00000005, 32'h0, 32'h0, 1);
        drain();
        chk("bps0_count", 64'(rx_cnt - start), 64'd32);
        chk("bps0_cfg_err", 64'(cfg_err), 64'd1);
        send_frame(4, 32'h89ABCDEF, 32'h0, 32'h0, 1);
        drain();
        chk("cfg_err_sticky", 64'(cfg_err), 64'd1);
        start = rx_cnt;
        send_frame(12, 32'h11223344, 32'h0, 32'h0, 1);
        drain();
        chk("bps12_count", 64'(rx_cnt - start), 64'd4);
        chk("bps12_final", 64'(rx_last), 64'h11);

        // Reset in the middle of a frame, then a clean frame must start from bit 0
        start = rx_cnt;
        send_frame(4, 32'hFEDCBA98, 32'h0, 32'h0, 1);
        n = 0;
        while (rx_cnt - start < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("rst_mid_pre", 64'(rx_cnt - start >= 3), 64'd1);
        rstf = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_i_valid", 64'(i_valid), 64'd0);
        chk("rst_mid_t0_ready", 64'(t0_ready), 64'd0);
        chk("rst_mid_i_last", 64'(i_last), 64'd0);
        chk("rst_mid_cfg_err", 64'(cfg_err), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstf = 1'b1;
        @(posedge clk); #1;
        start = rx_cnt;
        send_frame(4, 32'h76543210, 32'h0, 32'h0, 1);
        drain();
        chk("post_rst_count", 64'(rx_cnt - start), 64'd8);
        chk("post_rst_final", 64'(rx_last), 64'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
